// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: rx oversampling tick, tx bit tick, baud square wave.
// Run-time rate select from four divisors, switched only at bit boundaries.
module uart_baud_gen #(
   parameter int DIV_W = 8,
   parameter int OVS   = 16,
   parameter int DIV0  = 33,
   parameter int DIV1  = 16,
   parameter int DIV2  = 65,
   parameter int DIV3  = 130
) (
   input  logic       osc_clk,
   input  logic       nrst,
   input  logic       en,
   input  logic [1:0] div_sel,
   output logic       rx_tick,
   output logic       tx_tick,
   output logic       bd_clk,
   output logic       rate_ack,
   output logic [1:0] cur_sel
);

   localparam int OVS_W = $clog2(OVS);

   localparam logic [DIV_W-1:0] MAX0 = DIV_W'(DIV0 - 1);
   localparam logic [DIV_W-1:0] MAX1 = DIV_W'(DIV1 - 1);
   localparam logic [DIV_W-1:0] MAX2 = DIV_W'(DIV2 - 1);
   localparam logic [DIV_W-1:0] MAX3 = DIV_W'(DIV3 - 1);

   localparam logic [OVS_W-1:0] OVS_TOP  = OVS_W'(OVS - 1);
   localparam logic [OVS_W-1:0] OVS_HALF = OVS_W'(OVS / 2);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_max;
   logic [OVS_W-1:0] ovs_cnt;
   logic [OVS_W-1:0] ovs_nxt;
   logic             div_wrap;
   logic             bit_end;
   logic             req;
   logic             apply;
   logic             pend;
   logic             ack_d;

   // Terminal count of the divisor selected by the active (registered) rate
   always_comb begin
      div_max = MAX0;
      unique case (cur_sel)
         2'd0:    div_max = MAX0;
         2'd1:    div_max = MAX1;
         2'd2:    div_max = MAX2;
         2'd3:    div_max = MAX3;
         default: div_max = MAX0;
      endcase
   end

   assign div_wrap = (div_cnt == div_max);
   assign bit_end  = div_wrap && (ovs_cnt == OVS_TOP);
   assign ovs_nxt  = ovs_cnt + OVS_W'(div_wrap);
   assign req      = (div_sel != cur_sel);
   assign apply    = en && bit_end && pend && req;

   // Divisor and oversample counters with registered tick / square-wave outputs
   always_ff @(posedge osc_clk or negedge nrst) begin
      if (!nrst) begin
         div_cnt <= '0;
         ovs_cnt <= '0;
         rx_tick <= 1'b0;
         tx_tick <= 1'b0;
         bd_clk  <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         ovs_cnt <= '0;
         rx_tick <= 1'b0;
         tx_tick <= 1'b0;
         bd_clk  <= 1'b0;
      end else begin
         div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
         ovs_cnt <= ovs_nxt;
         rx_tick <= div_wrap;
         tx_tick <= bit_end;
         bd_clk  <= (ovs_nxt >= OVS_HALF);
      end
   end

   // Rate switch: immediate while idle, otherwise deferred to the bit boundary
   always_ff @(posedge osc_clk or negedge nrst) begin
      if (!nrst) begin
         cur_sel  <= 2'd0;
         pend     <= 1'b0;
         ack_d    <= 1'b0;
         rate_ack <= 1'b0;
      end else begin
         rate_ack <= ack_d;
         if (!en) begin
            cur_sel <= div_sel;
            ack_d   <= req;
            pend    <= 1'b0;
         end else if (apply) begin
            cur_sel <= div_sel;
            ack_d   <= 1'b1;
            pend    <= 1'b0;
         end else begin
            ack_d   <= 1'b0;
            pend    <= req;
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: scoreboard of expected tick/ack edge indices.
// Each window counts edges from 0; edge i's outputs are sampled 1 ns later.
`timescale 1ns/1ps
module tb_uart_baud_gen;

   logic       osc_clk = 1'b0;
   logic       nrst;
   logic       en;
   logic [1:0] div_sel;
   logic       rx_tick;
   logic       tx_tick;
   logic       bd_clk;
   logic       rate_ack;
   logic [1:0] cur_sel;

   int checks = 0;
   int errors = 0;

   int         rx_q[$];
   int         tx_q[$];
   int         ack_q[$];
   int         chg_at_q[$];
   logic [1:0] chg_val_q[$];
   int         en_off_at;
   int         en_on_at;
   int         bd_d;

   uart_baud_gen dut (
      .osc_clk  (osc_clk),
      .nrst     (nrst),
      .en       (en),
      .div_sel  (div_sel),
      .rx_tick  (rx_tick),
      .tx_tick  (tx_tick),
      .bd_clk   (bd_clk),
      .rate_ack (rate_ack),
      .cur_sel  (cur_sel)
   );

   always #100 osc_clk = ~osc_clk;

   task automatic clear_plan();
      rx_q.delete();
      tx_q.delete();
      ack_q.delete();
      chg_at_q.delete();
      chg_val_q.delete();
      en_off_at = -1;
      en_on_at  = -1;
      bd_d      = 0;
   endtask

   task automatic expect_ticks(input int start, input int d, input int lim);
      for (int k = 1; start + k * d - 1 < lim; k++) begin
         rx_q.push_back(start + k * d - 1);
         if (k % 16 == 0) tx_q.push_back(start + k * d - 1);
      end
   endtask

   task automatic add_chg(input int at, input logic [1:0] v);
      chg_at_q.push_back(at);
      chg_val_q.push_back(v);
   endtask

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge osc_clk);
         #1;
      end
   endtask

   task automatic watch(input string name, input int n);
      bit   en_s;
      logic bd_e;
      int   e;
      for (int i = 0; i < n; i++) begin
         if (i == en_off_at) en = 1'b0;
         if (i == en_on_at) en = 1'b1;
         while (chg_at_q.size() > 0 && chg_at_q[0] == i) begin
            void'(chg_at_q.pop_front());
            div_sel = chg_val_q.pop_front();
         end
         en_s = en;
         @(posedge osc_clk);
         #1;
         if (rx_tick === 1'b1) begin
            checks++;
            if (rx_q.size() == 0) begin
               errors++;
               $display("FAIL %s rx_tick: unexpected at edge %0d", name, i);
            end else begin
               e = rx_q.pop_front();
               if (e != i) begin
                  errors++;
                  $display("FAIL %s rx_tick: at edge %0d, required %0d", name, i, e);
               end
            end
         end
         if (tx_tick === 1'b1) begin
            checks++;
            if (tx_q.size() == 0) begin
               errors++;
               $display("FAIL %s tx_tick: unexpected at edge %0d", name, i);
            end else begin
               e = tx_q.pop_front();
               if (e != i) begin
                  errors++;
                  $display("FAIL %s tx_tick: at edge %0d, required %0d", name, i, e);
               end
            end
         end
         if (rate_ack === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin
               errors++;
               $display("FAIL %s rate_ack: unexpected at edge %0d", name, i);
            end else begin
               e = ack_q.pop_front();
               if (e != i) begin
                  errors++;
                  $display("FAIL %s rate_ack: at edge %0d, required %0d", name, i, e);
               end
            end
         end
         if (!en_s) begin
            checks++;
            if ({rx_tick, tx_tick, bd_clk} !== 3'b000) begin
               errors++;
               $display("FAIL %s idle: rx/tx/bd=%b%b%b at edge %0d, required 000",
                        name, rx_tick, tx_tick, bd_clk, i);
            end
         end else if (bd_d > 0) begin
            bd_e = (((i + 1) / bd_d) % 16) >= 8;
            checks++;
            if (bd_clk !== bd_e) begin
               errors++;
               $display("FAIL %s bd_clk: %b at edge %0d, required %b", name, bd_clk, i, bd_e);
            end
         end
      end
      while (rx_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL %s rx_tick: missing, required at edge %0d", name, rx_q.pop_front());
      end
      while (tx_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL %s tx_tick: missing, required at edge %0d", name, tx_q.pop_front());
      end
      while (ack_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL %s rate_ack: missing, required at edge %0d", name, ack_q.pop_front());
      end
   endtask

   task automatic check_sel(input string name, input logic [1:0] exp);
      checks++;
      if (cur_sel !== exp) begin
         errors++;
         $display("FAIL %s cur_sel: %0d, required %0d", name, cur_sel, exp);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      en = 1'b1;
      div_sel = 2'd0;
      #5;
      checks++;
      if ({rx_tick, tx_tick, bd_clk, rate_ack, cur_sel} !== 6'b0) begin
         errors++;
         $display("FAIL reset outputs: %b%b%b%b sel=%0d, required all 0",
                  rx_tick, tx_tick, bd_clk, rate_ack, cur_sel);
      end
      edges(3);
      checks++;
      if ({rx_tick, tx_tick, bd_clk, rate_ack, cur_sel} !== 6'b0) begin
         errors++;
         $display("FAIL reset hold: %b%b%b%b sel=%0d, required all 0",
                  rx_tick, tx_tick, bd_clk, rate_ack, cur_sel);
      end
      nrst = 1'b1;
   endtask

   task automatic test_default(input string name);
      clear_plan();
      bd_d = 33;
      expect_ticks(0, 33, 1100);
      watch(name, 1100);
      check_sel(name, 2'd0);
   endtask

   task automatic test_en_drop();
      en = 1'b0;
      edges(2);
      clear_plan();
      en = 1'b1;
      en_off_at = 100;
      en_on_at  = 150;
      expect_ticks(0, 33, 100);
      expect_ticks(150, 33, 800);
      watch("en_drop", 800);
   endtask

   task automatic test_live_change();
      en = 1'b0;
      div_sel = 2'd0;
      edges(2);
      clear_plan();
      en = 1'b1;
      add_chg(50, 2'd1);
      expect_ticks(0, 33, 528);
      expect_ticks(528, 16, 1100);
      ack_q.push_back(528);
      watch("live_change", 1100);
      check_sel("live_change", 2'd1);
   endtask

   task automatic test_change_disabled();
      en = 1'b0;
      edges(2);
      clear_plan();
      div_sel = 2'd3;
      en_on_at = 4;
      ack_q.push_back(1);
      expect_ticks(4, 130, 2200);
      watch("change_disabled", 2200);
      check_sel("change_disabled", 2'd3);
   endtask

   task automatic test_multi();
      en = 1'b0;
      div_sel = 2'd0;
      edges(3);
      clear_plan();
      en = 1'b1;
      add_chg(40, 2'd2);
      add_chg(200, 2'd3);
      expect_ticks(0, 33, 528);
      expect_ticks(528, 130, 700);
      ack_q.push_back(528);
      watch("multi", 700);
      check_sel("multi", 2'd3);
   endtask

   task automatic test_cancel();
      en = 1'b0;
      div_sel = 2'd0;
      edges(3);
      clear_plan();
      en = 1'b1;
      bd_d = 33;
      add_chg(40, 2'd1);
      add_chg(200, 2'd0);
      expect_ticks(0, 33, 1100);
      watch("cancel", 1100);
      check_sel("cancel", 2'd0);
   endtask

   task automatic test_async_reset();
      en = 1'b0;
      div_sel = 2'd2;
      edges(3);
      en = 1'b1;
      edges(300);
      div_sel = 2'd1;
      edges(300);
      check_sel("async_pre", 2'd2);
      @(posedge osc_clk);
      #7;
      nrst = 1'b0;
      #1;
      checks++;
      if ({rx_tick, tx_tick, bd_clk, rate_ack, cur_sel} !== 6'b0) begin
         errors++;
         $display("FAIL async_reset outputs: %b%b%b%b sel=%0d, required all 0",
                  rx_tick, tx_tick, bd_clk, rate_ack, cur_sel);
      end
      div_sel = 2'd0;
      en = 1'b1;
      @(posedge osc_clk);
      #1;
      nrst = 1'b1;
      test_default("after_reset");
   endtask

   initial begin
      clear_plan();
      test_reset();
      test_default("default");
      test_en_drop();
      test_live_change();
      test_change_disabled();
      test_multi();
      test_cancel();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
